// File: rtl/bridge_pkg.sv
// Shared definitions for the inter-bus UART bridge: packet byte layout, mode
// encoding, receive byte-FSM states and bit-timing helper.
package bridge_pkg;

  localparam logic [1:0] BYTE_IDX_DATA    = 2'd0;
  localparam logic [1:0] BYTE_IDX_ADDR_LO = 2'd1;
  localparam logic [1:0] BYTE_IDX_ADDR_HI = 2'd2;

  localparam logic BRIDGE_MODE_READ  = 1'b0;
  localparam logic BRIDGE_MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic int clks_per_bit(input int clock_frequency, input int baudrate);
    return clock_frequency / baudrate;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, start/data/stop FSM and bit counter.
// Define BRIDGE_RX_PARITY_EN for 8E1 framing (even parity); default is 8N1.
module uart_rx_byte
  import bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             rx_prev;
  logic             start_edge;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_p0;
  logic             par_bad;

  // Stage p0/p1: synchronizer; rx_prev is the falling-edge reference.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_p0 <= uart_rx;
      sync_p1 <= sync_p0;
      rx_prev <= sync_p1;
    end
  end

  assign start_edge = rx_prev & ~sync_p1;
  assign cnt_zero   = (cnt == '0);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RX_IDLE: begin
        if (start_edge) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt_zero) state_nxt = sync_p1 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (cnt_zero && (bit_idx == 3'd7)) begin
`ifdef BRIDGE_RX_PARITY_EN
          state_nxt = RX_PARITY;
`else
          state_nxt = RX_STOP;
`endif
        end
      end
      RX_PARITY: begin
        if (cnt_zero) state_nxt = RX_STOP;
      end
      RX_STOP: begin
        if (cnt_zero) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Idle keeps the half-bit preload ready so the start-bit centre is found
  // without an extra load cycle; every later interval is a full bit.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (state == RX_IDLE) begin
      cnt     <= HALF_BIT;
      bit_idx <= '0;
    end else if (cnt_zero) begin
      cnt <= FULL_BIT;
      if (state == RX_DATA) bit_idx <= bit_idx + 3'd1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if ((state == RX_DATA) && cnt_zero) shift_p0 <= {sync_p1, shift_p0[7:1]};
  end

`ifdef BRIDGE_RX_PARITY_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      par_bad <= 1'b0;
    end else if ((state == RX_PARITY) && cnt_zero) begin
      par_bad <= ^{shift_p0, sync_p1};
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  // A parity failure is reported at the stop sample, like a bad stop bit.
  always_comb begin
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    if ((state == RX_STOP) && cnt_zero) begin
      if (sync_p1 && !par_bad) byte_valid = 1'b1;
      else                     byte_err   = 1'b1;
    end
  end

  assign byte_data = shift_p0;

endmodule

// File: rtl/bridge_uart_rx.sv
// Bridge link receiver: assembles 3-byte packets {data, addr_lo, mode/addr_hi}
// from uart_rx_byte into a one-entry valid/ready buffer. Parity via BRIDGE_RX_PARITY_EN.
module bridge_uart_rx
  import bridge_pkg::*;
#(
  parameter int BAUDRATE        = 19200,
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int ADDR_WIDTH      = 12
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic                  pkt_mode,
  output logic [ADDR_WIDTH-1:0] pkt_addr,
  output logic [7:0]            pkt_data,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUDRATE);

  logic                  byte_valid;
  logic                  byte_err;
  logic [7:0]            byte_data;
  logic [1:0]            idx;
  logic [7:0]            data_slot;
  logic [7:0]            addr_lo_slot;
  logic                  pkt_done;
  logic                  accept;
  logic                  load;
  logic                  new_mode;
  logic [ADDR_WIDTH-1:0] new_addr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clock     (clock),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_err  (byte_err)
  );

  // Assembler: byte2 is consumed straight off the receiver, not stored.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      idx <= BYTE_IDX_DATA;
    end else if (byte_err) begin
      idx <= BYTE_IDX_DATA;
    end else if (byte_valid) begin
      idx <= (idx == BYTE_IDX_ADDR_HI) ? BYTE_IDX_DATA : idx + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (byte_valid && (idx == BYTE_IDX_DATA))    data_slot    <= byte_data;
    if (byte_valid && (idx == BYTE_IDX_ADDR_LO)) addr_lo_slot <= byte_data;
  end

  assign pkt_done = byte_valid && (idx == BYTE_IDX_ADDR_HI);
  assign accept   = pkt_valid && pkt_ready;
  assign load     = pkt_done && (!pkt_valid || pkt_ready);
  assign new_mode = byte_data[7] ? BRIDGE_MODE_WRITE : BRIDGE_MODE_READ;
  assign new_addr = ADDR_WIDTH'({byte_data[4:0], addr_lo_slot});

  // Output buffer: a full, unaccepted buffer keeps the older packet.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pkt_valid <= 1'b0;
      pkt_mode  <= BRIDGE_MODE_READ;
      pkt_addr  <= '0;
      pkt_data  <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= byte_err;
      overflow  <= pkt_done && pkt_valid && !pkt_ready;
      if (load) begin
        pkt_valid <= 1'b1;
        pkt_mode  <= new_mode;
        pkt_addr  <= new_addr;
        pkt_data  <= data_slot;
      end else if (accept) begin
        pkt_valid <= 1'b0;
      end
    end
  end

endmodule
